// File: rtl/debug_pkg.sv
// Shared definitions for the debug panel: view modes, derived widths and
// the active-low 7-segment code table (segment a in bit 0, g in bit 6).
package debug_pkg;

   typedef enum logic [1:0] {
      MODE_MANUAL     = 2'b00,
      MODE_AUTO       = 2'b01,
      MODE_FREEZE     = 2'b10,
      MODE_MANUAL_ALT = 2'b11
   } mode_t;

   function automatic int cur_w(input int n_words);
      return (n_words > 1) ? $clog2(n_words) : 1;
   endfunction

   function automatic int bsel_w(input int word_w);
      return ($clog2(word_w / 8) > 1) ? $clog2(word_w / 8) : 1;
   endfunction

   function automatic int digits(input int word_w);
      return word_w / 4;
   endfunction

   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'h0: return 7'h40;
         4'h1: return 7'h79;
         4'h2: return 7'h24;
         4'h3: return 7'h30;
         4'h4: return 7'h19;
         4'h5: return 7'h12;
         4'h6: return 7'h02;
         4'h7: return 7'h78;
         4'h8: return 7'h00;
         4'h9: return 7'h10;
         4'hA: return 7'h08;
         4'hB: return 7'h03;
         4'hC: return 7'h46;
         4'hD: return 7'h21;
         4'hE: return 7'h06;
         default: return 7'h0E;
      endcase
   endfunction

endpackage

// File: rtl/button_debounce.sv
// Active-low push-button: 2-flop synchroniser, debouncer and a one-cycle
// pulse on each accepted press.
module button_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
   input  logic clock,
   input  logic resetn,
   input  logic btn_n,
   output logic press
);

   localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync_a, sync_b, level, armed;
   logic [CNT_W-1:0] cnt;
   logic             target, accept;

   // Until a stable release is seen after reset, only a high level counts,
   // so a button held through reset never yields a press.
   always_comb begin
      target = armed ? ~level : 1'b1;
      accept = (sync_b == target) && (cnt == CNT_LAST);
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         sync_a <= 1'b1;
         sync_b <= 1'b1;
         level  <= 1'b1;
         armed  <= 1'b0;
         cnt    <= '0;
         press  <= 1'b0;
      end else begin
         sync_a <= btn_n;
         sync_b <= sync_a;
         press  <= 1'b0;
         if (sync_b != target) begin
            cnt <= '0;
         end else if (accept) begin
            cnt   <= '0;
            armed <= 1'b1;
            if (armed) begin
               level <= sync_b;
               press <= ~sync_b;
            end
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/hex_decoder.sv
// One hex digit to its active-low 7-segment pattern.
module hex_decoder
   import debug_pkg::*;
(
   input  logic [3:0] digit,
   output logic [6:0] seg_n
);

   always_comb seg_n = seg7(digit);

endmodule

// File: rtl/debug_panel.sv
// Switch register plus a cursor-driven viewer over a bus of probe words,
// with manual, auto-scroll and freeze modes and 7-segment output.
module debug_panel
   import debug_pkg::*;
#(
   parameter int unsigned WORD_W          = 16,
   parameter int unsigned N_WORDS         = 32,
   parameter int unsigned DEBOUNCE_CYCLES = 250000,
   parameter int unsigned SCROLL_PERIOD   = 50000000,
   localparam int unsigned CUR_W          = cur_w(N_WORDS),
   localparam int unsigned BSEL_W         = bsel_w(WORD_W),
   localparam int unsigned DIGITS         = digits(WORD_W)
) (
   input  logic                      clock,
   input  logic                      resetn,
   input  logic [7:0]                sw,
   input  logic [BSEL_W-1:0]         byte_sel,
   input  logic                      btn_load,
   input  logic                      btn_next,
   input  logic                      btn_prev,
   input  logic [1:0]                mode,
   input  logic [N_WORDS*WORD_W-1:0] probe,
   output logic [WORD_W-1:0]         switch_word,
   output logic [CUR_W-1:0]          cursor,
   output logic [WORD_W-1:0]         view_word,
   output logic [7*DIGITS-1:0]       hex_word,
   output logic [13:0]               hex_cursor,
   output logic                      frozen,
   output logic                      nonzero
);

   localparam int unsigned SC_W = (SCROLL_PERIOD > 1) ? $clog2(SCROLL_PERIOD) : 1;
   localparam logic [SC_W-1:0]  SC_LAST  = SC_W'(SCROLL_PERIOD - 1);
   localparam logic [CUR_W-1:0] CUR_LAST = CUR_W'(N_WORDS - 1);

   logic                      load_p, next_p, prev_p;
   logic [N_WORDS*WORD_W-1:0] snapshot;
   logic [SC_W-1:0]           scroll_cnt, scroll_nxt;
   logic [CUR_W-1:0]          cursor_nxt, cur_inc, cur_dec;
   logic [WORD_W-1:0]         sw_nxt, live_sel, snap_sel;
   logic [7:0]                cur_ext;
   logic                      auto_on, freeze_on, scroll_tc;
   mode_t                     mode_v;

   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_load (
      .clock(clock), .resetn(resetn), .btn_n(btn_load), .press(load_p));
   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_next (
      .clock(clock), .resetn(resetn), .btn_n(btn_next), .press(next_p));
   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_prev (
      .clock(clock), .resetn(resetn), .btn_n(btn_prev), .press(prev_p));

   always_comb begin
      mode_v    = mode_t'(mode);
      auto_on   = (mode_v == MODE_AUTO);
      freeze_on = (mode_v == MODE_FREEZE);
      scroll_tc = auto_on && (scroll_cnt == SC_LAST);
      cur_inc   = (cursor == CUR_LAST) ? '0 : cursor + 1'b1;
      cur_dec   = (cursor == '0) ? CUR_LAST : cursor - 1'b1;

      // Buttons take priority over the scroll step and restart its count.
      cursor_nxt = cursor;
      if (next_p && !prev_p)      cursor_nxt = cur_inc;
      else if (prev_p && !next_p) cursor_nxt = cur_dec;
      else if (!next_p && !prev_p && scroll_tc) cursor_nxt = cur_inc;

      if (!auto_on || next_p || prev_p || scroll_tc) scroll_nxt = '0;
      else                                           scroll_nxt = scroll_cnt + 1'b1;

      sw_nxt = switch_word;
      if (load_p) begin
         for (int unsigned b = 0; b < WORD_W / 8; b++) begin
            if (32'(byte_sel) == b) sw_nxt[b*8 +: 8] = sw;
         end
      end

      live_sel = '0;
      snap_sel = '0;
      for (int unsigned k = 0; k < N_WORDS; k++) begin
         if (cursor == CUR_W'(k)) begin
            live_sel = probe[k*WORD_W +: WORD_W];
            snap_sel = snapshot[k*WORD_W +: WORD_W];
         end
      end

      cur_ext = '0;
      cur_ext[CUR_W-1:0] = cursor;
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         switch_word <= '0;
         cursor      <= '0;
         view_word   <= '0;
         snapshot    <= '0;
         scroll_cnt  <= '0;
         frozen      <= 1'b0;
      end else begin
         switch_word <= sw_nxt;
         cursor      <= cursor_nxt;
         scroll_cnt  <= scroll_nxt;
         frozen      <= freeze_on;
         view_word   <= frozen ? snap_sel : live_sel;
         if (freeze_on && !frozen) snapshot <= probe;
      end
   end

   assign nonzero = |switch_word;

   for (genvar g = 0; g < DIGITS; g++) begin : g_hex_word
      hex_decoder u_hex (.digit(view_word[4*g +: 4]), .seg_n(hex_word[7*g +: 7]));
   end

   hex_decoder u_hex_cur_lo (.digit(cur_ext[3:0]), .seg_n(hex_cursor[6:0]));
   hex_decoder u_hex_cur_hi (.digit(cur_ext[7:4]), .seg_n(hex_cursor[13:7]));

endmodule

// File: tb/tb_debug_panel.sv
// Scoreboard bench for debug_panel with short debounce and scroll periods.
module tb_debug_panel;

   localparam int unsigned WORD_W = 16;
   localparam int unsigned N_WORDS = 5;
   localparam int unsigned DEB = 4;
   localparam int unsigned SP = 8;

   logic                      clock, resetn;
   logic [7:0]                sw;
   logic [0:0]                byte_sel;
   logic                      btn_load, btn_next, btn_prev;
   logic [1:0]                mode;
   logic [N_WORDS*WORD_W-1:0] probe;
   logic [WORD_W-1:0]         switch_word, view_word;
   logic [2:0]                cursor;
   logic [27:0]               hex_word;
   logic [13:0]               hex_cursor;
   logic                      frozen, nonzero;

   typedef struct {
      string       tag;
      logic [31:0] val;
   } exp_t;

   exp_t exp_q[$];
   int   n_vec = 0;
   int   n_bad = 0;

   debug_panel #(
      .WORD_W(WORD_W), .N_WORDS(N_WORDS),
      .DEBOUNCE_CYCLES(DEB), .SCROLL_PERIOD(SP)
   ) dut (
      .clock(clock), .resetn(resetn), .sw(sw), .byte_sel(byte_sel),
      .btn_load(btn_load), .btn_next(btn_next), .btn_prev(btn_prev),
      .mode(mode), .probe(probe), .switch_word(switch_word), .cursor(cursor),
      .view_word(view_word), .hex_word(hex_word), .hex_cursor(hex_cursor),
      .frozen(frozen), .nonzero(nonzero)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "timeout");
   end

   function automatic logic [6:0] seg_ref(input int d);
      logic [6:0] tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
      return tbl[d];
   endfunction

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
      end
   endtask

   task automatic sb_push(input string tag, input logic [31:0] v);
      exp_t e;
      e.tag = tag;
      e.val = v;
      exp_q.push_back(e);
   endtask

   task automatic sb_check(input logic [31:0] act);
      exp_t e;
      if (exp_q.size() == 0) begin
         check_val("sb_underflow", 32'(exp_q.size()), 32'd1);
      end else begin
         e = exp_q.pop_front();
         check_val(e.tag, act, e.val);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic set_word(input int k, input logic [15:0] v);
      probe[k*16 +: 16] = v;
   endtask

   // 0 = load, 1 = next, 2 = prev, 3 = next and prev together
   task automatic press(input int which);
      btn_load = (which != 0);
      btn_next = !(which == 1 || which == 3);
      btn_prev = !(which == 2 || which == 3);
      tick(10);
      btn_load = 1'b1;
      btn_next = 1'b1;
      btn_prev = 1'b1;
      tick(10);
   endtask

   initial begin
      resetn = 1'b0;
      sw = '0;
      byte_sel = '0;
      btn_load = 1'b1;
      btn_next = 1'b1;
      btn_prev = 1'b1;
      mode = 2'b00;
      probe = '0;
      set_word(0, 16'h0F0F);
      set_word(1, 16'hA5A5);
      set_word(2, 16'h1234);
      set_word(3, 16'hBEEF);
      set_word(4, 16'h0001);
      tick(3);

      sb_push("rst_switch", 32'h0);   sb_check(32'(switch_word));
      sb_push("rst_cursor", 32'h0);   sb_check(32'(cursor));
      sb_push("rst_view", 32'h0);     sb_check(32'(view_word));
      sb_push("rst_frozen", 32'h0);   sb_check(32'(frozen));
      sb_push("rst_nonzero", 32'h0);  sb_check(32'(nonzero));
      sb_push("rst_hexcur", 32'({seg_ref(0), seg_ref(0)})); sb_check(32'(hex_cursor));

      resetn = 1'b1;
      sb_push("view_w0", 32'h0F0F);
      tick(12);
      sb_check(32'(view_word));

      // switch register loads
      sw = 8'hAB; byte_sel = 1'b1;
      sb_push("load_hi", 32'hAB00);
      press(0);
      sb_check(32'(switch_word));
      sw = 8'hCD; byte_sel = 1'b0;
      sb_push("load_lo", 32'hABCD);
      sb_push("nonzero", 32'h1);
      press(0);
      sb_check(32'(switch_word));
      sb_check(32'(nonzero));

      // glitch then clean presses
      btn_next = 1'b0; tick(2); btn_next = 1'b1;
      sb_push("glitch", 32'h0);
      tick(10);
      sb_check(32'(cursor));
      for (int i = 1; i <= 5; i++) begin
         sb_push($sformatf("next_%0d", i), 32'(i % 5));
         press(1);
         sb_check(32'(cursor));
      end
      sb_push("prev_wrap", 32'h4);
      sb_push("view_w4", 32'h0001);
      press(2);
      sb_check(32'(cursor));
      sb_check(32'(view_word));

      // auto-scroll
      mode = 2'b01;
      sb_push("auto_hold", 32'h4);
      sb_push("auto_wrap", 32'h0);
      sb_push("auto_step", 32'h1);
      tick(7); sb_check(32'(cursor));
      tick(1); sb_check(32'(cursor));
      tick(8); sb_check(32'(cursor));
      // press timed to land on the next terminal count
      tick(1);
      btn_next = 1'b0;
      sb_push("tc_before", 32'h1);
      sb_push("tc_press", 32'h2);
      sb_push("tc_gap", 32'h2);
      sb_push("tc_after", 32'h3);
      tick(6); sb_check(32'(cursor));
      tick(1); sb_check(32'(cursor));
      tick(3); btn_next = 1'b1;
      tick(4); sb_check(32'(cursor));
      tick(1); sb_check(32'(cursor));

      // asynchronous reset mid-scroll with next held
      btn_next = 1'b0;
      tick(4);
      #2 resetn = 1'b0;
      #1;
      sb_push("arst_cursor", 32'h0);  sb_check(32'(cursor));
      sb_push("arst_switch", 32'h0);  sb_check(32'(switch_word));
      sb_push("arst_view", 32'h0);    sb_check(32'(view_word));
      sb_push("arst_nonzero", 32'h0); sb_check(32'(nonzero));
      mode = 2'b00;
      tick(2);
      resetn = 1'b1;
      sb_push("held_no_press", 32'h0);
      tick(20);
      sb_check(32'(cursor));
      btn_next = 1'b1;
      tick(10);
      sb_push("restart_press", 32'h1);
      press(1);
      sb_check(32'(cursor));
      sb_push("cursor_2", 32'h2);
      press(1);
      sb_check(32'(cursor));

      // freeze
      mode = 2'b10;
      sb_push("frz_on", 32'h1);
      sb_push("frz_view", 32'h1234);
      sb_push("frz_hold", 32'h1234);
      tick(2);
      sb_check(32'(frozen));
      sb_check(32'(view_word));
      set_word(2, 16'h5678);
      tick(2);
      sb_check(32'(view_word));
      mode = 2'b00;
      sb_push("frz_off", 32'h0);
      sb_push("live_view", 32'h5678);
      tick(1); sb_check(32'(frozen));
      tick(1); sb_check(32'(view_word));
      mode = 2'b10;
      sb_push("resnap", 32'h5678);
      tick(2); sb_check(32'(view_word));
      set_word(3, 16'h0000);
      sb_push("snap_nav", 32'hBEEF);
      press(1);
      sb_check(32'(view_word));
      mode = 2'b00;
      sb_push("live_w3", 32'h0000);
      tick(2); sb_check(32'(view_word));

      // simultaneous next/prev and hex outputs
      sb_push("back_to_2", 32'h2);
      press(2);
      sb_check(32'(cursor));
      set_word(2, 16'h1234);
      sb_push("both_btn", 32'h2);
      sb_push("hex_view", 32'h1234);
      sb_push("hex_d0", 32'(seg_ref(4)));
      sb_push("hex_d3", 32'(seg_ref(1)));
      sb_push("hex_cur", 32'({seg_ref(0), seg_ref(2)}));
      press(3);
      sb_check(32'(cursor));
      sb_check(32'(view_word));
      sb_check(32'(hex_word[6:0]));
      sb_check(32'(hex_word[27:21]));
      sb_check(32'(hex_cursor));

      check_val("sb_left", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
